playseq_controller: RTL

Controller FSM for the PlaySeq game. It sequences the 16x4 synchronous RAM holding the reference sequence. First it plays entries 0..nivel on the LEDs with fixed on/off times. Then it reads back the same entries and compares each against the player's button press, reporting hit, miss or timeout. The controller sits between the board I/O (start key, buttons, LEDs) and the RAM, whose write enable is tied low at the top level.

---
 rtl/playseq_pkg.sv | 23 ++
 rtl/playseq_timer.sv | 18 +
 rtl/playseq_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/playseq_pkg.sv
// playseq_pkg: state codes and default timing constants shared by the PlaySeq controller and its debug decoder.
package playseq_pkg;
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_SHOW     = 4'd2,
    S_GAP      = 4'd3,
    S_IN_FETCH = 4'd4,
    S_WAIT_IN  = 4'd5,
    S_CHECK    = 4'd6,
    S_WAIT_REL = 4'd7,
    S_ACERTO   = 4'd8,
    S_ERRO     = 4'd9
  } state_t;
  localparam int T_ON_DEF      = 1000;
  localparam int T_OFF_DEF     = 500;
  localparam int T_TIMEOUT_DEF = 5000;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/playseq_timer.sv
// playseq_timer: cycle counter with clear/enable; done_o flags that the count equals the terminal value.
module playseq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign done_o = (cnt_q == tc_i);
endmodule

// File: rtl/playseq_controller.sv
// playseq_controller: plays RAM entries 0..nivel on the LEDs, then checks the player's presses against them.
module playseq_controller
  import playseq_pkg::*;
#(
  parameter int T_ON      = T_ON_DEF,
  parameter int T_OFF     = T_OFF_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] nivel,
  input  logic [3:0] botoes,
  input  logic [3:0] ram_q,
  output logic [3:0] ram_addr,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  localparam int W = $clog2(max3(T_ON, T_OFF, T_TIMEOUT)) + 1;
  localparam logic [W-1:0] TC_ON  = W'(T_ON - 1);
  localparam logic [W-1:0] TC_OFF = W'(T_OFF - 1);
  localparam logic [W-1:0] TC_TO  = W'(T_TIMEOUT - 1);
  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d, nivel_q, nivel_d, jogada_q, jogada_d;
  logic       acertou_q, acertou_d, errou_q, errou_d, timeout_q, timeout_d;
  logic       done, tmr_en;
  logic [W-1:0] tc;
  // One timer serves every timed state; it restarts on each state change.
  assign tmr_en = (state_q == S_SHOW) || (state_q == S_GAP) || (state_q == S_WAIT_IN);
  assign tc = (state_q == S_SHOW) ? TC_ON : (state_q == S_GAP) ? TC_OFF : TC_TO;
  playseq_timer #(.W(W)) u_timer (
    .clk(clk), .reset(reset), .clr_i(state_d != state_q), .en_i(tmr_en), .tc_i(tc), .done_o(done)
  );
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nivel_d   = nivel_q;
    jogada_d  = jogada_q;
    acertou_d = acertou_q;
    errou_d   = errou_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_ACERTO, S_ERRO:
        if (iniciar) begin
          state_d   = S_FETCH;
          addr_d    = '0;
          nivel_d   = nivel;
          acertou_d = 1'b0;
          errou_d   = 1'b0;
          timeout_d = 1'b0;
        end
      S_FETCH: state_d = S_SHOW;
      S_SHOW:  state_d = done ? S_GAP : S_SHOW;
      S_GAP:
        if (done) begin
          state_d = (addr_q == nivel_q) ? S_IN_FETCH : S_FETCH;
          addr_d  = (addr_q == nivel_q) ? 4'd0 : addr_q + 4'd1;
        end
      S_IN_FETCH: state_d = S_WAIT_IN;
      S_WAIT_IN:
        if (botoes != 4'd0) begin
          jogada_d = botoes;
          state_d  = S_CHECK;
        end else if (done) begin
          timeout_d = 1'b1;
          errou_d   = 1'b1;
          state_d   = S_ERRO;
        end
      S_CHECK:
        if (jogada_q != ram_q) begin
          errou_d = 1'b1;
          state_d = S_ERRO;
        end else if (addr_q == nivel_q) begin
          acertou_d = 1'b1;
          state_d   = S_ACERTO;
        end else state_d = S_WAIT_REL;
      S_WAIT_REL:
        if (botoes == 4'd0) begin
          addr_d  = addr_q + 4'd1;
          state_d = S_IN_FETCH;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      nivel_q   <= '0;
      jogada_q  <= '0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      nivel_q   <= nivel_d;
      jogada_q  <= jogada_d;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
      timeout_q <= timeout_d;
    end
  assign ram_addr  = addr_q;
  assign leds      = (state_q == S_SHOW) ? ram_q : 4'd0;
  assign pronto    = (state_q == S_ACERTO) || (state_q == S_ERRO);
  assign acertou   = acertou_q;
  assign errou     = errou_q;
  assign timeout   = timeout_q;
  assign db_estado = state_q;
endmodule
